// File: rtl/reorder_buffer.sv
// In-order retirement buffer for the Tomasulo core: allocates rename tags at dispatch,
// captures CDB results, forwards completed values and retires one entry per cycle.
module reorder_buffer #(
    parameter int DEPTH  = 15,
    parameter int TAG_W  = 4,
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_in,
    input  logic              dis_valid_in,
    input  logic              dis_has_dest_in,
    input  logic [REG_W-1:0]  dis_rd_in,
    output logic              dis_ready_out,
    output logic [TAG_W-1:0]  dis_tag_out,
    input  logic              cdb_valid_in,
    input  logic [TAG_W-1:0]  cdb_tag_in,
    input  logic [WORD_W-1:0] cdb_data_in,
    input  logic [TAG_W-1:0]  qj_tag_in,
    input  logic [TAG_W-1:0]  qk_tag_in,
    output logic              qj_ready_out,
    output logic              qk_ready_out,
    output logic [WORD_W-1:0] qj_data_out,
    output logic [WORD_W-1:0] qk_data_out,
    output logic              rob_commit_signal_out,
    output logic [TAG_W-1:0]  rob_commit_tag_out,
    output logic [WORD_W-1:0] rob_commit_data_out,
    output logic [REG_W-1:0]  rob_commit_target_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_ready;
    logic [DEPTH-1:0]  r_has_dest;
    logic [REG_W-1:0]  r_rd   [DEPTH];
    logic [WORD_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              r_commit_sig;
    logic [TAG_W-1:0]  r_commit_tag;
    logic [WORD_W-1:0] r_commit_data;
    logic [REG_W-1:0]  r_commit_target;

    logic              w_full;
    logic              w_empty;
    logic              w_dis_fire;
    logic              w_retire;
    logic              w_cdb_hit;
    logic [PTR_W-1:0]  w_cdb_idx;
    logic [PTR_W-1:0]  w_qj_idx;
    logic [PTR_W-1:0]  w_qk_idx;
    logic [PTR_W-1:0]  w_head_nxt;
    logic [PTR_W-1:0]  w_tail_nxt;

    always_comb begin
        w_full     = (r_count == CNT_W'(DEPTH));
        w_empty    = (r_count == '0);
        w_dis_fire = dis_valid_in && !w_full;
        w_retire   = !w_empty && r_ready[r_head];

        w_head_nxt = (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + PTR_W'(1);
        w_tail_nxt = (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + PTR_W'(1);

        // Tag t lives in entry t-1; tag 0 and tags beyond DEPTH never match.
        w_cdb_idx = PTR_W'(cdb_tag_in - TAG_W'(1));
        w_qj_idx  = PTR_W'(qj_tag_in - TAG_W'(1));
        w_qk_idx  = PTR_W'(qk_tag_in - TAG_W'(1));

        w_cdb_hit = cdb_valid_in && (cdb_tag_in != '0) && (cdb_tag_in <= TAG_W'(DEPTH))
                    && r_busy[w_cdb_idx];

        qj_ready_out = (qj_tag_in != '0) && (qj_tag_in <= TAG_W'(DEPTH))
                       && r_busy[w_qj_idx] && r_ready[w_qj_idx];
        qk_ready_out = (qk_tag_in != '0) && (qk_tag_in <= TAG_W'(DEPTH))
                       && r_busy[w_qk_idx] && r_ready[w_qk_idx];
        qj_data_out  = qj_ready_out ? r_data[w_qj_idx] : '0;
        qk_data_out  = qk_ready_out ? r_data[w_qk_idx] : '0;

        dis_ready_out = !w_full;
        dis_tag_out   = TAG_W'(r_tail) + TAG_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy          <= '0;
            r_ready         <= '0;
            r_has_dest      <= '0;
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_commit_sig    <= 1'b0;
            r_commit_tag    <= '0;
            r_commit_data   <= '0;
            r_commit_target <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else if (flush_in) begin
            r_busy       <= '0;
            r_ready      <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_commit_sig <= 1'b0;
        end else begin
            if (w_dis_fire) begin
                r_busy[r_tail]     <= 1'b1;
                r_ready[r_tail]    <= 1'b0;
                r_has_dest[r_tail] <= dis_has_dest_in;
                r_rd[r_tail]       <= dis_rd_in;
                r_tail             <= w_tail_nxt;
            end

            if (w_cdb_hit) begin
                r_ready[w_cdb_idx] <= 1'b1;
                r_data[w_cdb_idx]  <= cdb_data_in;
            end

            // Entries without a destination retire silently; the payload holds its last value.
            r_commit_sig <= w_retire && r_has_dest[r_head];
            if (w_retire) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= w_head_nxt;
                if (r_has_dest[r_head]) begin
                    r_commit_tag    <= TAG_W'(r_head) + TAG_W'(1);
                    r_commit_data   <= r_data[r_head];
                    r_commit_target <= r_rd[r_head];
                end
            end

            unique case ({w_dis_fire, w_retire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rob_commit_signal_out = r_commit_sig;
    assign rob_commit_tag_out    = r_commit_tag;
    assign rob_commit_data_out   = r_commit_data;
    assign rob_commit_target_out = r_commit_target;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: stimulus pushes expected commits, a negedge
// monitor pops and compares every commit pulse; direct checks cover tags, full and forwarding.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_in = 1'b0;
    logic        dis_valid_in = 1'b0;
    logic        dis_has_dest_in = 1'b0;
    logic [4:0]  dis_rd_in = '0;
    logic        dis_ready_out;
    logic [3:0]  dis_tag_out;
    logic        cdb_valid_in = 1'b0;
    logic [3:0]  cdb_tag_in = '0;
    logic [31:0] cdb_data_in = '0;
    logic [3:0]  qj_tag_in = '0;
    logic [3:0]  qk_tag_in = '0;
    logic        qj_ready_out;
    logic        qk_ready_out;
    logic [31:0] qj_data_out;
    logic [31:0] qk_data_out;
    logic        rob_commit_signal_out;
    logic [3:0]  rob_commit_tag_out;
    logic [31:0] rob_commit_data_out;
    logic [4:0]  rob_commit_target_out;

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] data;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    reorder_buffer #(
        .DEPTH  (15),
        .TAG_W  (4),
        .WORD_W (32),
        .REG_W  (5)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush_in              (flush_in),
        .dis_valid_in          (dis_valid_in),
        .dis_has_dest_in       (dis_has_dest_in),
        .dis_rd_in             (dis_rd_in),
        .dis_ready_out         (dis_ready_out),
        .dis_tag_out           (dis_tag_out),
        .cdb_valid_in          (cdb_valid_in),
        .cdb_tag_in            (cdb_tag_in),
        .cdb_data_in           (cdb_data_in),
        .qj_tag_in             (qj_tag_in),
        .qk_tag_in             (qk_tag_in),
        .qj_ready_out          (qj_ready_out),
        .qk_ready_out          (qk_ready_out),
        .qj_data_out           (qj_data_out),
        .qk_data_out           (qk_data_out),
        .rob_commit_signal_out (rob_commit_signal_out),
        .rob_commit_tag_out    (rob_commit_tag_out),
        .rob_commit_data_out   (rob_commit_data_out),
        .rob_commit_target_out (rob_commit_target_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic dispatch(input logic has_dest, input logic [4:0] rd);
        dis_valid_in    = 1'b1;
        dis_has_dest_in = has_dest;
        dis_rd_in       = rd;
        step();
        dis_valid_in    = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
        cdb_valid_in = 1'b1;
        cdb_tag_in   = tag;
        cdb_data_in  = data;
        step();
        cdb_valid_in = 1'b0;
    endtask

    task automatic expect_commit(input logic [3:0] tag, input logic [31:0] data,
                                 input logic [4:0] rd);
        sb_q.push_back('{tag: tag, data: data, rd: rd});
    endtask

    // Monitor: every commit pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rob_commit_signal_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got tag %0d data %0h rd %0d expected none",
                         rob_commit_tag_out, rob_commit_data_out, rob_commit_target_out);
            end else begin
                mon_e = sb_q.pop_front();
                check("commit_tag", 32'(rob_commit_tag_out), 32'(mon_e.tag));
                check("commit_data", rob_commit_data_out, mon_e.data);
                check("commit_target", 32'(rob_commit_target_out), 32'(mon_e.rd));
            end
        end
    end

    initial begin
        // Asynchronous reset: outputs must be at reset values without a clock edge.
        #1 rst = 1'b0;
        qj_tag_in = 4'd1;
        qk_tag_in = 4'd2;
        #2;
        check("rst_dis_ready", 32'(dis_ready_out), 32'd1);
        check("rst_dis_tag", 32'(dis_tag_out), 32'd1);
        check("rst_commit_sig", 32'(rob_commit_signal_out), 32'd0);
        check("rst_commit_tag", 32'(rob_commit_tag_out), 32'd0);
        check("rst_commit_data", rob_commit_data_out, 32'd0);
        check("rst_commit_target", 32'(rob_commit_target_out), 32'd0);
        check("rst_qj_ready", 32'(qj_ready_out), 32'd0);
        check("rst_qj_data", qj_data_out, 32'd0);
        idle(2);
        rst = 1'b1;
        idle(1);

        // Three dispatches: tags 1,2,3.
        check("tag_before", 32'(dis_tag_out), 32'd1);
        dispatch(1'b1, 5'd1);
        check("tag_after1", 32'(dis_tag_out), 32'd2);
        dispatch(1'b1, 5'd2);
        check("tag_after2", 32'(dis_tag_out), 32'd3);
        dispatch(1'b1, 5'd3);
        check("tag_after3", 32'(dis_tag_out), 32'd4);
        idle(3);

        // Out-of-order completion, in-order retirement.
        expect_commit(4'd1, 32'hA, 5'd1);
        expect_commit(4'd2, 32'hB, 5'd2);
        expect_commit(4'd3, 32'hC, 5'd3);
        cdb(4'd3, 32'hC);
        cdb(4'd1, 32'hA);
        cdb(4'd2, 32'hB);
        idle(5);
        check("sb_drain_inorder", 32'(sb_q.size()), 32'd0);

        // Tags 4..7; tag 6 has no destination and must retire silently.
        dispatch(1'b1, 5'd7);
        dispatch(1'b1, 5'd8);
        dispatch(1'b0, 5'd9);
        dispatch(1'b1, 5'd10);
        qj_tag_in = 4'd5;
        qk_tag_in = 4'd4;
        cdb(4'd5, 32'h1234);
        check("fwd_qj_ready", 32'(qj_ready_out), 32'd1);
        check("fwd_qj_data", qj_data_out, 32'h1234);
        check("fwd_qk_notready", 32'(qk_ready_out), 32'd0);
        check("fwd_qk_data0", qk_data_out, 32'd0);
        expect_commit(4'd4, 32'h44, 5'd7);
        expect_commit(4'd5, 32'h1234, 5'd8);
        expect_commit(4'd7, 32'h77, 5'd10);
        cdb(4'd6, 32'h66);
        cdb(4'd7, 32'h77);
        check("fwd_qj_held", qj_data_out, 32'h1234);
        cdb(4'd4, 32'h44);
        idle(6);
        check("fwd_qj_retired_ready", 32'(qj_ready_out), 32'd0);
        check("fwd_qj_retired_data", qj_data_out, 32'd0);
        check("sb_drain_silent", 32'(sb_q.size()), 32'd0);

        // Flush to restart at tag 1, then fill all 15 entries.
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        check("flush_tag", 32'(dis_tag_out), 32'd1);
        for (int i = 0; i < 15; i++) dispatch(1'b1, 5'(i + 1));
        check("full_ready", 32'(dis_ready_out), 32'd0);
        check("full_tag_wrapped", 32'(dis_tag_out), 32'd1);
        dispatch(1'b1, 5'd31);
        check("full_refused_tag", 32'(dis_tag_out), 32'd1);
        check("full_refused_ready", 32'(dis_ready_out), 32'd0);

        expect_commit(4'd1, 32'h100, 5'd1);
        cdb(4'd1, 32'h100);
        step();
        check("after_retire_ready", 32'(dis_ready_out), 32'd1);
        check("after_retire_tag", 32'(dis_tag_out), 32'd1);
        dispatch(1'b1, 5'd20);
        check("realloc_tag", 32'(dis_tag_out), 32'd2);
        check("realloc_full", 32'(dis_ready_out), 32'd0);

        // Dispatch in the same cycle as a retire while full is refused.
        expect_commit(4'd2, 32'h200, 5'd2);
        cdb(4'd2, 32'h200);
        dispatch(1'b1, 5'd21);
        check("full_retire_tag", 32'(dis_tag_out), 32'd2);
        check("full_retire_ready", 32'(dis_ready_out), 32'd1);
        idle(2);
        check("sb_drain_full", 32'(sb_q.size()), 32'd0);

        // Flush with two completed (not head) entries: nothing commits.
        qj_tag_in = 4'd5;
        qk_tag_in = 4'd7;
        cdb(4'd5, 32'h555);
        cdb(4'd7, 32'h777);
        check("pre_flush_fwd", qj_data_out, 32'h555);
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        check("post_flush_tag", 32'(dis_tag_out), 32'd1);
        check("post_flush_ready", 32'(dis_ready_out), 32'd1);
        check("post_flush_qj", 32'(qj_ready_out), 32'd0);
        check("post_flush_qk", 32'(qk_ready_out), 32'd0);
        idle(3);
        dispatch(1'b1, 5'd6);
        expect_commit(4'd1, 32'hABC, 5'd6);
        cdb(4'd1, 32'hABC);
        idle(3);
        check("post_flush_tag2", 32'(dis_tag_out), 32'd2);

        // Reset asserted mid-retire: the pending pulse and the next retire are dropped.
        dispatch(1'b1, 5'd2);
        dispatch(1'b1, 5'd3);
        qj_tag_in = 4'd3;
        cdb(4'd2, 32'h22);
        cdb(4'd3, 32'h33);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_sig", 32'(rob_commit_signal_out), 32'd0);
        check("mid_rst_tag", 32'(rob_commit_tag_out), 32'd0);
        check("mid_rst_data", rob_commit_data_out, 32'd0);
        check("mid_rst_target", 32'(rob_commit_target_out), 32'd0);
        check("mid_rst_dis_tag", 32'(dis_tag_out), 32'd1);
        check("mid_rst_dis_ready", 32'(dis_ready_out), 32'd1);
        check("mid_rst_qj_ready", 32'(qj_ready_out), 32'd0);
        check("mid_rst_qj_data", qj_data_out, 32'd0);
        idle(3);
        rst = 1'b1;
        idle(5);
        check("sb_drain_final", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
